// File: rtl/s2_pkg.sv
// rtl/s2_pkg.sv - shared stage-1/stage-2 feature-map constants and writer FSM states
package s2_pkg;

  localparam int DATA_W      = 17;
  localparam int ROWS        = 8;
  localparam int COLS        = 8;
  localparam int CHANS       = 3;
  localparam int ADDR_W      = 8;
  localparam int FRAME_WORDS = ROWS * COLS * CHANS;

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_FILL          = 2'd1,
    ST_DONE          = 2'd2,
    ST_WAIT_CONSUMER = 2'd3
  } wr_state_e;

endpackage

// File: rtl/s1_bram_writer_if.sv
// rtl/s1_bram_writer_if.sv - valid/ready input stream carrying stage-1 results into the writer
interface s1_bram_writer_if #(
  parameter int DATA_W = s2_pkg::DATA_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/s1_addr_gen.sv
// rtl/s1_addr_gen.sv - row/col/channel counters (channel fastest) and BRAM address concatenation
module s1_addr_gen #(
  parameter int ROWS   = s2_pkg::ROWS,
  parameter int COLS   = s2_pkg::COLS,
  parameter int CHANS  = s2_pkg::CHANS,
  parameter int ADDR_W = s2_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int CHA_W = $clog2(CHANS);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [CHA_W-1:0] cha;

  logic row_max, col_max, cha_max;

  assign row_max = (row == ROW_W'(ROWS - 1));
  assign col_max = (col == COL_W'(COLS - 1));
  assign cha_max = (cha == CHA_W'(CHANS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
      cha <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
      cha <= '0;
    end else if (inc) begin
      if (cha_max) begin
        cha <= '0;
        if (col_max) begin
          col <= '0;
          row <= row_max ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        cha <= cha + 1'b1;
      end
    end
  end

  // Channel occupies the top bits so each channel plane is a contiguous block
  assign addr = ADDR_W'({cha, row, col});
  assign last = row_max && col_max && cha_max;

endmodule

// File: rtl/s1_bram_writer.sv
// rtl/s1_bram_writer.sv - stage-1 feature-map BRAM writer with consumer handshake
// Optional ReLU clamp on written data when S1_WRITER_RELU_EN is defined.
module s1_bram_writer #(
  parameter int DATA_W = s2_pkg::DATA_W,
  parameter int ROWS   = s2_pkg::ROWS,
  parameter int COLS   = s2_pkg::COLS,
  parameter int CHANS  = s2_pkg::CHANS,
  parameter int ADDR_W = s2_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  s1_bram_writer_if.slave     in_s,
  input  logic                consumer_busy,
  output logic                we,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic                data_done,
  output logic                frame_busy
);

  s2_pkg::wr_state_e state, state_nxt;

  logic              xfer;
  logic              frame_start;
  logic              seen_busy;
  logic              last_word;
  logic [ADDR_W-1:0] gen_addr;
  logic [DATA_W-1:0] wr_val;

  assign in_s.in_ready = (state == s2_pkg::ST_FILL);
  assign xfer          = in_s.in_valid && in_s.in_ready;
  assign frame_start   = (state == s2_pkg::ST_IDLE) && start;
  assign frame_busy    = (state != s2_pkg::ST_IDLE);

  s1_addr_gen #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .CHANS  (CHANS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (frame_start),
    .inc   (xfer),
    .addr  (gen_addr),
    .last  (last_word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      s2_pkg::ST_IDLE:          if (start) state_nxt = s2_pkg::ST_FILL;
      s2_pkg::ST_FILL:          if (xfer && last_word) state_nxt = s2_pkg::ST_DONE;
      s2_pkg::ST_DONE:          state_nxt = s2_pkg::ST_WAIT_CONSUMER;
      s2_pkg::ST_WAIT_CONSUMER: if (!consumer_busy && seen_busy) state_nxt = s2_pkg::ST_IDLE;
      default:                  state_nxt = s2_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= s2_pkg::ST_IDLE;
    else        state <= state_nxt;
  end

  // The reader must be seen busy at least once before its idle flag releases us
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   seen_busy <= 1'b0;
    else if (state != s2_pkg::ST_WAIT_CONSUMER)   seen_busy <= 1'b0;
    else if (consumer_busy)                       seen_busy <= 1'b1;
  end

  always_comb begin
    wr_val = in_s.in_data;
`ifdef S1_WRITER_RELU_EN
    if (in_s.in_data[DATA_W-1]) wr_val = '0;
`endif
  end

  // Address/data hold their last value across input gaps; only we drops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we         <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      data_done  <= 1'b0;
    end else begin
      we        <= xfer;
      data_done <= (state == s2_pkg::ST_DONE);
      if (xfer) begin
        write_addr <= gen_addr;
        write_data <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_s1_bram_writer.sv
// tb/tb_s1_bram_writer.sv - randomized self-checking bench for s1_bram_writer (honours S1_WRITER_RELU_EN)
module tb_s1_bram_writer;

  localparam int DW = 17;
  localparam int AW = 8;
  localparam int NW = 192;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          consumer_busy = 1'b0;
  logic          we;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          data_done;
  logic          frame_busy;

  s1_bram_writer_if #(.DATA_W(DW)) bus ();

  always #5 clk = ~clk;

  s1_bram_writer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .in_s          (bus),
    .consumer_busy (consumer_busy),
    .we            (we),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .data_done     (data_done),
    .frame_busy    (frame_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int done_cyc[$];
  logic [DW-1:0] vals [NW];

  always @(negedge clk) begin
    if (we) begin
      wq_addr.push_back(int'(write_addr));
      wq_data.push_back(int'(write_data));
      wq_cyc.push_back(cyc);
    end
    if (data_done) done_cyc.push_back(cyc);
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int k);
    return (k % 3) * 64 + (k / 24) * 8 + (k / 3) % 8;
  endfunction

  function automatic logic [DW-1:0] exp_wdata(input logic [DW-1:0] v);
`ifdef S1_WRITER_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // mode 0: back-to-back, 1: in_valid toggles, 2: random gaps plus stray start pulses
  task automatic fill_frame(input int mode, input int stop_after, output int sent);
    int  guard;
    logic acc;
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_cyc.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sent  = 0;
    guard = 0;
    while (sent < stop_after && guard < 4000) begin
      case (mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = guard[0] ? 1'b0 : 1'b1;
        default: begin
          bus.in_valid = ($urandom_range(0, 2) != 0);
          start        = ($urandom_range(0, 15) == 0);
        end
      endcase
      bus.in_data = vals[sent];
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      guard++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    if (guard >= 4000) check("fill_timeout", 32'(sent), 32'(stop_after));
  endtask

  task automatic finish_frame(input int mode);
    int  i;
    bit  seen;
    check("in_ready_drop", 32'(bus.in_ready), 32'd0);
    seen = 1'b0;
    for (i = 0; i < 20; i++) begin
      if (data_done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("data_done_seen", 32'(seen), 32'd1);
    @(negedge clk); #1;
    check("write_count", 32'(wq_addr.size()), 32'(NW));
    for (int k = 0; k < NW && k < wq_addr.size(); k++) begin
      check($sformatf("addr[%0d]", k), 32'(wq_addr[k]), 32'(exp_addr(k)));
      check($sformatf("data[%0d]", k), 32'(wq_data[k]), 32'(exp_wdata(vals[k])));
    end
    if (wq_addr.size() == NW) begin
      if (mode == 0) check("we_consecutive", 32'(wq_cyc[NW-1] - wq_cyc[0]), 32'(NW - 1));
      check("done_pulses", 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() > 0) check("done_after_last_we", 32'(done_cyc[0] - wq_cyc[NW-1]), 32'd1);
    end
    check("busy_after_done", 32'(frame_busy), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("wait_holds_no_busy", 32'(frame_busy), 32'd1);
    consumer_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("wait_holds_busy", 32'(frame_busy), 32'd1);
    consumer_busy = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("return_idle", 32'(frame_busy), 32'd0);
    @(posedge clk); #1;
    check("start_at_exit_ignored", 32'(frame_busy), 32'd0);
  endtask

  int sent;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(write_addr), 32'd0);
    check("rst_data", 32'(write_data), 32'd0);
    check("rst_done", 32'(data_done), 32'd0);
    check("rst_busy", 32'(frame_busy), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("idle_ignores_valid", 32'(we), 32'd0);

    for (int k = 0; k < NW; k++) vals[k] = DW'(k);
    fill_frame(0, NW, sent);
    finish_frame(0);
    check("word4_addr", 32'(wq_addr[4]), 32'd65);
    check("word191_addr", 32'(wq_addr[191]), 32'd191);

    for (int k = 0; k < NW; k++) vals[k] = DW'($urandom);
    fill_frame(1, NW, sent);
    finish_frame(1);

    for (int k = 0; k < NW; k++) vals[k] = DW'($urandom);
    vals[0] = 17'h1FFFF;
    vals[1] = 17'h00005;
    fill_frame(2, NW, sent);
    finish_frame(2);
`ifdef S1_WRITER_RELU_EN
    check("relu_neg", 32'(wq_data[0]), 32'd0);
`else
    check("pass_neg", 32'(wq_data[0]), 32'h1FFFF);
`endif
    check("pos_word", 32'(wq_data[1]), 32'd5);

    for (int k = 0; k < NW; k++) vals[k] = DW'($urandom);
    fill_frame(0, 100, sent);
    reset = 1'b0;
    #1;
    check("midrst_we", 32'(we), 32'd0);
    check("midrst_addr", 32'(write_addr), 32'd0);
    check("midrst_data", 32'(write_data), 32'd0);
    check("midrst_done", 32'(data_done), 32'd0);
    check("midrst_busy", 32'(frame_busy), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    fill_frame(0, NW, sent);
    check("post_reset_addr0", 32'(wq_addr.size() > 0 ? wq_addr[0] : -1), 32'd0);
    finish_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
